// File: rtl/zelda_pkg.sv
// Constants and types shared by the game's sprite blitters.
package zelda_pkg;

  localparam int SPRITE_W = 16;
  localparam int SPRITE_H = 16;
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int COLOR_W  = 9;

  localparam logic [COLOR_W-1:0] TRANSP = 9'h1FF;

  localparam logic [1:0] DIR_DOWN  = 2'd0;
  localparam logic [1:0] DIR_UP    = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } blit_state_t;

endpackage

// File: rtl/sprite_scan_counter.sv
// Row/column scan counter for sprite blitters: column is the fast index,
// row advances when the column wraps.
module sprite_scan_counter #(
  parameter int COL_W = 4,
  parameter int ROW_W = 4
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_clear,
  input  logic             i_step,
  output logic [COL_W-1:0] o_col,
  output logic [ROW_W-1:0] o_row,
  output logic             o_last
);

  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] r_row;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_col <= '0;
      r_row <= '0;
    end else if (i_clear) begin
      r_col <= '0;
      r_row <= '0;
    end else if (i_step) begin
      r_col <= r_col + 1'b1;
      if (&r_col) r_row <= r_row + 1'b1;
    end
  end

  assign o_col  = r_col;
  assign o_row  = r_row;
  assign o_last = (&r_col) & (&r_row);

endmodule

// File: rtl/draw_link_sprite.sv
// Blits Link's sprite frame for the current facing direction from the sprite
// ROM into the frame buffer, skipping colour-keyed and off-screen pixels.
module draw_link_sprite
  import zelda_pkg::*;
#(
  parameter int                 SPRITE_W = zelda_pkg::SPRITE_W,
  parameter int                 SPRITE_H = zelda_pkg::SPRITE_H,
  parameter int                 SCREEN_W = zelda_pkg::SCREEN_W,
  parameter int                 SCREEN_H = zelda_pkg::SCREEN_H,
  parameter int                 COLOR_W  = zelda_pkg::COLOR_W,
  parameter logic [COLOR_W-1:0] TRANSP   = zelda_pkg::TRANSP,
  localparam int                COL_W    = $clog2(SPRITE_W),
  localparam int                ROW_W    = $clog2(SPRITE_H),
  localparam int                ADDR_W   = 2 + COL_W + ROW_W
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_draw_link,
  input  logic [7:0]         i_link_x,
  input  logic [6:0]         i_link_y,
  input  logic [1:0]         i_link_dir,
  output logic [ADDR_W-1:0]  o_rom_addr,
  input  logic [COLOR_W-1:0] i_rom_data,
  output logic [7:0]         o_fb_x,
  output logic [6:0]         o_fb_y,
  output logic [COLOR_W-1:0] o_fb_colour,
  output logic               o_fb_we,
  output logic               o_draw_link_done
);

  blit_state_t        r_state, w_state_next;
  logic [7:0]         r_x;
  logic [6:0]         r_y;
  logic [1:0]         r_dir;
  logic [8:0]         r_px_x;
  logic [7:0]         r_px_y;
  logic               r_pix_valid;
  logic [COLOR_W-1:0] r_colour;
  logic               w_start, w_step, w_last, w_in_range, w_fb_we;
  logic [COL_W-1:0]   w_col;
  logic [ROW_W-1:0]   w_row;

  sprite_scan_counter #(.COL_W(COL_W), .ROW_W(ROW_W)) u_scan (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_clear (w_start),
    .i_step  (w_step),
    .o_col   (w_col),
    .o_row   (w_row),
    .o_last  (w_last)
  );

  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_step       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_draw_link) begin
          w_state_next = S_FETCH;
          w_start      = 1'b1;
        end
      end
      S_FETCH: begin
        if (!i_draw_link) begin
          w_state_next = S_IDLE;
        end else begin
          w_step = 1'b1;
          if (w_last) w_state_next = S_DRAIN;
        end
      end
      S_DRAIN: w_state_next = i_draw_link ? S_DONE : S_IDLE;
      S_DONE:  if (!i_draw_link) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_x         <= '0;
      r_y         <= '0;
      r_dir       <= '0;
      r_px_x      <= '0;
      r_px_y      <= '0;
      r_pix_valid <= 1'b0;
      r_colour    <= '0;
    end else begin
      r_state     <= w_state_next;
      r_pix_valid <= w_step;
      if (w_start) begin
        r_x   <= i_link_x;
        r_y   <= i_link_y;
        r_dir <= i_link_dir;
      end
      // Coordinates are one bit wider so sprites hanging off the edge clip instead of wrapping.
      if (w_step) begin
        r_px_x <= {1'b0, r_x} + 9'(w_col);
        r_px_y <= {1'b0, r_y} + 8'(w_row);
      end
      if (w_fb_we) r_colour <= i_rom_data;
    end
  end

  assign w_in_range = (r_px_x < 9'(SCREEN_W)) && (r_px_y < 8'(SCREEN_H));
  assign w_fb_we    = r_pix_valid && (i_rom_data != TRANSP) && w_in_range;

  assign o_rom_addr       = {r_dir, w_row, w_col};
  assign o_fb_x           = r_px_x[7:0];
  assign o_fb_y           = r_px_y[6:0];
  assign o_fb_colour      = w_fb_we ? i_rom_data : r_colour;
  assign o_fb_we          = w_fb_we;
  assign o_draw_link_done = (r_state == S_DONE);

endmodule

// File: tb/tb_draw_link_sprite.sv
// Randomized bench for draw_link_sprite: expected frame-buffer writes are derived
// per draw from the sprite ROM contents, position and clipping rules.
module tb_draw_link_sprite;
  import zelda_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       draw_link = 1'b0;
  logic [7:0] link_x = '0;
  logic [6:0] link_y = '0;
  logic [1:0] link_dir = '0;
  logic [9:0] rom_addr;
  logic [8:0] rom_data = '0;
  logic [7:0] fb_x;
  logic [6:0] fb_y;
  logic [8:0] fb_colour;
  logic       fb_we;
  logic       done;

  logic [8:0] rom_mem [0:1023];
  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int rel;
    int x;
    int y;
    int c;
  } wr_t;

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  draw_link_sprite dut (
    .i_clock          (clk),
    .i_reset          (rst),
    .i_draw_link      (draw_link),
    .i_link_x         (link_x),
    .i_link_y         (link_y),
    .i_link_dir       (link_dir),
    .o_rom_addr       (rom_addr),
    .i_rom_data       (rom_data),
    .o_fb_x           (fb_x),
    .o_fb_y           (fb_y),
    .o_fb_colour      (fb_colour),
    .o_fb_we          (fb_we),
    .o_draw_link_done (done)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check_val({tag, "_rom_addr"}, 32'(rom_addr), 0);
    check_val({tag, "_fb_x"}, 32'(fb_x), 0);
    check_val({tag, "_fb_y"}, 32'(fb_y), 0);
    check_val({tag, "_fb_colour"}, 32'(fb_colour), 0);
    check_val({tag, "_fb_we"}, 32'(fb_we), 0);
    check_val({tag, "_done"}, 32'(done), 0);
  endtask

  // One sprite draw starting at cycle T; rel counts cycles after T.
  task automatic run_draw(input int x, input int y, input int dir,
                          input int abort_at, input int reset_at, input string name);
    wr_t exp_q[$];
    wr_t got_q[$];
    wr_t w;
    int  last_wr_rel, last_addr_rel, addr_err, done_rel, done_exp, pix, n_cmp;

    addr_err = 0;
    done_rel = 0;
    last_wr_rel   = (abort_at > 0) ? abort_at : ((reset_at > 0) ? reset_at - 1 : 257);
    last_addr_rel = (last_wr_rel < 256) ? last_wr_rel : 256;

    // Pixel (r,c) is fetched at rel 1+16r+c and written one cycle later.
    for (int r = 0; r < 16; r++) begin
      for (int c = 0; c < 16; c++) begin
        w.rel = 2 + r * 16 + c;
        pix   = int'(rom_mem[dir * 256 + r * 16 + c]);
        if (w.rel <= last_wr_rel && pix != int'(TRANSP) &&
            x + c < SCREEN_W && y + r < SCREEN_H) begin
          w.x = x + c;
          w.y = y + r;
          w.c = pix;
          exp_q.push_back(w);
        end
      end
    end

    @(posedge clk); #1;
    link_x    = 8'(x);
    link_y    = 7'(y);
    link_dir  = 2'(dir);
    draw_link = 1'b1;

    for (int rel = 1; rel <= 300; rel++) begin
      @(posedge clk); #1;
      if (rel == abort_at) draw_link = 1'b0;
      if (rel == reset_at) rst = 1'b1;
      @(negedge clk);
      if (rel == reset_at) begin
        check_zero_outputs({name, "_midreset"});
        break;
      end
      if (fb_we) begin
        w.rel = rel;
        w.x   = int'(fb_x);
        w.y   = int'(fb_y);
        w.c   = int'(fb_colour);
        got_q.push_back(w);
      end
      if (rel <= last_addr_rel && int'(rom_addr) != dir * 256 + rel - 1) addr_err++;
      if (done && done_rel == 0) done_rel = rel;
      if (done_rel != 0) break;
      if (abort_at > 0 && rel >= abort_at + 10) break;
    end

    check_val({name, "_nwrites"}, 32'(got_q.size()), 32'(exp_q.size()));
    n_cmp = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n_cmp; i++) begin
      check_val({name, "_wr_pos"},
                32'(got_q[i].rel * 65536 + got_q[i].x * 256 + got_q[i].y),
                32'(exp_q[i].rel * 65536 + exp_q[i].x * 256 + exp_q[i].y));
      check_val({name, "_wr_colour"}, 32'(got_q[i].c), 32'(exp_q[i].c));
    end
    check_val({name, "_addr_errs"}, 32'(addr_err), 0);
    done_exp = (abort_at > 0 || reset_at > 0) ? 0 : 258;
    check_val({name, "_done_rel"}, 32'(done_rel), 32'(done_exp));

    if (done_rel != 0) begin
      @(posedge clk); #1;
      draw_link = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check_val({name, "_done_fall"}, 32'(done), 0);
    end
    if (reset_at > 0) begin
      @(posedge clk); #1;
      draw_link = 1'b0;
      rst       = 1'b0;
    end

    $display("draw %s: x=%0d y=%0d dir=%0d writes=%0d expected=%0d done_rel=%0d",
             name, x, y, dir, got_q.size(), exp_q.size(), done_rel);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      rom_mem[i]       = 9'h007;
      rom_mem[256 + i] = ($urandom_range(0, 3) == 0) ? TRANSP : 9'($urandom_range(0, 510));
      rom_mem[512 + i] = ($urandom_range(0, 3) == 0) ? TRANSP : 9'($urandom_range(0, 510));
      rom_mem[768 + i] = (((i / 16) + (i % 16)) % 2 == 1) ? 9'h0F0 : TRANSP;
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    run_draw(10, 20, 0, 0, 0, "base");
    run_draw(0, 0, 3, 0, 0, "checker");
    run_draw(150, 110, 0, 0, 0, "clip_edge");
    run_draw(255, 127, 0, 0, 0, "offscreen");
    run_draw(40, 30, 1, 50, 0, "abort");
    run_draw(40, 30, 1, 0, 0, "restart");
    run_draw(60, 50, 2, 0, 100, "reset");
    run_draw(60, 50, 2, 0, 0, "fresh");
    for (int k = 0; k < 8; k++) begin
      run_draw(int'($urandom_range(0, 255)), int'($urandom_range(0, 127)),
               int'($urandom_range(0, 3)), 0, 0, "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
